cpu_sysid_checker: RTL and testbench
====================================

CPU_SYSID_CHECKER -- requirements
Module: cpu_sysid_checker

Interface
REQ-001 The block SHALL have parameter EXPECTED_ID, default 32'h11111111, meaning the required system ID word at word address 0.
REQ-002 The block SHALL have parameter EXPECTED_TIMESTAMP, default 32'h53037B79, meaning the required timestamp word at word address 1.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum waitrequest-stalled cycles per read; 0 disables the timeout.
REQ-004 The block SHALL have parameter AUTO_START, default 1, meaning one check runs automatically after reset release.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, a single-cycle request to run one check.
REQ-008 The block SHALL have port read, output, 1, the Avalon-MM master read strobe.
REQ-009 The block SHALL have port address, output, 1, the word address to the sysid slave (0 = ID, 1 = timestamp).
REQ-010 The block SHALL have port waitrequest, input, 1, the slave stall; readdata is valid in the cycle where read=1 and waitrequest=0.
REQ-011 The block SHALL have port readdata, input, 32, the slave read data.
REQ-012 The block SHALL have port busy, output, 1, high while a read is outstanding.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse at check completion.
REQ-014 The block SHALL have ports pass, fail and timeout, each output, 1, the sticky result flags.
REQ-015 The block SHALL have ports id_value and ts_value, each output, 32, the captured words.
REQ-016 The block SHALL have port mismatch_count, output, 8, a saturating count of failed checks.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_ID, RD_TS and DONE.
REQ-018 In IDLE and DONE, start=1 SHALL move the FSM to RD_ID and clear pass, fail and timeout on the same edge.
REQ-019 start SHALL be ignored in RD_ID and RD_TS.
REQ-020 When AUTO_START=1, the first cycle after reset release SHALL act as start=1.
REQ-021 In RD_ID, the block SHALL drive read=1 and address=0 and hold both stable while waitrequest=1.
REQ-022 In RD_ID, waitrequest=0 SHALL load readdata into id_value and move the FSM to RD_TS, with read staying 1 and address becoming 1 (back-to-back reads).
REQ-023 In RD_TS, waitrequest=0 SHALL load readdata into ts_value, drive read to 0 and move the FSM to DONE.
REQ-024 In the DONE cycle, done SHALL be 1.
REQ-025 On entry to DONE after a normal read, pass SHALL be 1 only if id_value==EXPECTED_ID and ts_value==EXPECTED_TIMESTAMP; otherwise fail SHALL be 1.
REQ-026 With waitrequest held at 0, latency SHALL be: start sampled at edge N, read=1 in cycles N+1 and N+2, done=1 in cycle N+3.
REQ-027 busy SHALL equal 1 exactly in RD_ID and RD_TS.
REQ-028 The stall counter SHALL reset to 0 on every accepted transfer and at the start of every read.
REQ-029 When TIMEOUT_CYCLES>0 and the stall counter reaches TIMEOUT_CYCLES stalled cycles, the block SHALL drive read to 0, set timeout=1 and fail=1, and enter DONE.
REQ-030 On a timeout, the word not yet captured SHALL retain its previous value.
REQ-031 mismatch_count SHALL increment by 1 when fail is set, and SHALL saturate at 255.
REQ-032 pass, fail, timeout, id_value and ts_value SHALL hold their values until the next accepted start.
REQ-033 pass and fail SHALL never both be 1.

Reset
REQ-034 On reset_n=0 at a clock edge, the block SHALL set FSM=IDLE, read=0, address=0, busy=0, done=0, pass=0, fail=0, timeout=0, id_value=0, ts_value=0, mismatch_count=0 and stall counter=0.
REQ-035 Reset asserted mid-transfer SHALL drop read at that edge and SHALL NOT produce a done pulse.

Verification
REQ-036 AUTO_START=1, zero-wait slave returning 0x11111111 and 0x53037B79 -> reads at addresses 0 then 1; done=1 and pass=1 three cycles after reset release; mismatch_count=0.
REQ-037 Slave returns 0x11111112 at address 0 -> fail=1, pass=0, id_value=0x11111112, mismatch_count=1.
REQ-038 waitrequest=1 for 3 cycles on each read -> read and address are stable while stalled; done=1 at start+9 with pass=1.
REQ-039 TIMEOUT_CYCLES=4, waitrequest stuck at 1 on address 1 -> read drops after 4 stalled cycles; timeout=1, fail=1; ts_value is unchanged.
REQ-040 start pulsed during RD_TS, then again in the DONE cycle -> the first pulse is ignored; the second starts a new check and clears the flags.
REQ-041 reset_n=0 during RD_ID stall -> read=0 at the next edge, no done pulse, and all outputs at their reset values.

Source files
------------

// File: rtl/cpu_sysid_checker.sv
// Reads the ID and timestamp words from an Avalon-MM sysid slave and compares
// them against the expected build values, with a stall timeout and sticky result flags.
module cpu_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h11111111,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h53037B79,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        read,
  output logic        address,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  mismatch_count
);

  localparam int unsigned SW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 32'd0);
  // The last stalled cycle is the one where the counter already holds TIMEOUT_CYCLES-1.
  localparam logic [SW-1:0] STALL_LIMIT = TO_EN ? SW'(TIMEOUT_CYCLES - 32'd1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          read_q, read_d;
  logic          addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          to_q, to_d;
  logic [31:0]   id_q, id_d;
  logic [31:0]   ts_q, ts_d;
  logic [7:0]    mc_q, mc_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          auto_q;
  logic          start_eff;
  logic          set_fail;

  assign start_eff = start | auto_q;

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    to_d     = to_q;
    id_d     = id_q;
    ts_d     = ts_q;
    stall_d  = stall_q;
    set_fail = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_eff) begin
          state_d = RD_ID;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          stall_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ID: begin
        if (!waitrequest) begin
          id_d    = readdata;
          state_d = RD_TS;
          stall_d = '0;
        end else if (TO_EN && (stall_q == STALL_LIMIT)) begin
          state_d  = DONE;
          to_d     = 1'b1;
          fail_d   = 1'b1;
          set_fail = 1'b1;
          stall_d  = '0;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      RD_TS: begin
        if (!waitrequest) begin
          ts_d    = readdata;
          state_d = DONE;
          stall_d = '0;
          if ((id_q == EXPECTED_ID) && (readdata == EXPECTED_TIMESTAMP)) begin
            pass_d = 1'b1;
          end else begin
            fail_d   = 1'b1;
            set_fail = 1'b1;
          end
        end else if (TO_EN && (stall_q == STALL_LIMIT)) begin
          state_d  = DONE;
          to_d     = 1'b1;
          fail_d   = 1'b1;
          set_fail = 1'b1;
          stall_d  = '0;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (set_fail && (mc_q != 8'hFF)) begin
      mc_d = mc_q + 8'd1;
    end else begin
      mc_d = mc_q;
    end

    // Bus strobes follow the next state so they are registered alongside it.
    read_d = (state_d == RD_ID) || (state_d == RD_TS);
    addr_d = (state_d == RD_TS);
    busy_d = read_d;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      id_q    <= 32'h0000_0000;
      ts_q    <= 32'h0000_0000;
      mc_q    <= 8'h00;
      stall_q <= '0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      mc_q    <= mc_d;
      stall_q <= stall_d;
      auto_q  <= 1'b0;
    end
  end

  assign read           = read_q;
  assign address        = addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timeout        = to_q;
  assign id_value       = id_q;
  assign ts_value       = ts_q;
  assign mismatch_count = mc_q;

endmodule

// File: tb/tb_cpu_sysid_checker.sv
// Scoreboard bench for cpu_sysid_checker: a behavioural sysid slave with
// programmable stalls, directed checks queued as expectations and popped on done.
module tb_cpu_sysid_checker;

  localparam logic [31:0] ID_OK  = 32'h11111111;
  localparam logic [31:0] ID_BAD = 32'h11111112;
  localparam logic [31:0] TS_OK  = 32'h53037B79;
  localparam logic [31:0] TS_ALT = 32'hDEADBEEF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        read, address, waitrequest, busy, done, pass, fail, timeout;
  logic [31:0] readdata, id_value, ts_value;
  logic [7:0]  mismatch_count;

  logic [31:0] sl_id = ID_OK;
  logic [31:0] sl_ts = TS_OK;
  int          sl_stall_id = 0;
  int          sl_stall_ts = 0;
  int          sl_cnt = 0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          c0;

  typedef struct {
    logic        p;
    logic        f;
    logic        t;
    logic [31:0] id;
    logic [31:0] ts;
    logic [7:0]  mc;
    int          dcyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic pr_read = 1'b0;
  logic pr_wait = 1'b0;
  logic pr_addr = 1'b0;

  always #5 clock = ~clock;

  cpu_sysid_checker #(.TIMEOUT_CYCLES(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .read           (read),
    .address        (address),
    .waitrequest    (waitrequest),
    .readdata       (readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .mismatch_count (mismatch_count)
  );

  // Slave stalls each read for a programmable number of cycles, then accepts it.
  assign readdata    = address ? sl_ts : sl_id;
  assign waitrequest = read && (sl_cnt < (address ? sl_stall_ts : sl_stall_id));

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset_n) sl_cnt <= 0;
    else if (read && waitrequest) sl_cnt <= sl_cnt + 1;
    else sl_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic p, input logic f, input logic t, input logic [31:0] id,
                      input logic [31:0] ts, input logic [7:0] mc, input int dcyc);
    exp_t x;
    x.p = p; x.f = f; x.t = t; x.id = id; x.ts = ts; x.mc = mc; x.dcyc = dcyc;
    sb.push_back(x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d pending checks expected 0 after %0d cycles", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_read"},    32'(read),           32'd0);
    chk({name, "_address"}, 32'(address),        32'd0);
    chk({name, "_busy"},    32'(busy),           32'd0);
    chk({name, "_done"},    32'(done),           32'd0);
    chk({name, "_pass"},    32'(pass),           32'd0);
    chk({name, "_fail"},    32'(fail),           32'd0);
    chk({name, "_timeout"}, 32'(timeout),        32'd0);
    chk({name, "_id"},      id_value,            32'd0);
    chk({name, "_ts"},      ts_value,            32'd0);
    chk({name, "_mcount"},  32'(mismatch_count), 32'd0);
  endtask

  // Monitor: bus stability while stalled, and scoreboard pop on every done pulse.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && pr_read && pr_wait && !done) begin
        chk("stall_read_hold", 32'(read), 32'd1);
        chk("stall_addr_hold", 32'(address), 32'(pr_addr));
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending check (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc),            32'(e.dcyc));
          chk("pass",       32'(pass),           32'(e.p));
          chk("fail",       32'(fail),           32'(e.f));
          chk("timeout",    32'(timeout),        32'(e.t));
          chk("id_value",   id_value,            e.id);
          chk("ts_value",   ts_value,            e.ts);
          chk("mcount",     32'(mismatch_count), 32'(e.mc));
          chk("done_read",  32'(read),           32'd0);
          chk("done_busy",  32'(busy),           32'd0);
        end
      end
      pr_read = read;
      pr_wait = waitrequest;
      pr_addr = address;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    check_reset("reset");

    // Auto-start after reset release, zero-wait slave, good words.
    c0 = cyc;
    reset_n = 1'b1;
    push(1'b1, 1'b0, 1'b0, ID_OK, TS_OK, 8'd0, c0 + 3);
    @(negedge clock);
    chk("auto_rd0_read", 32'(read), 32'd1);
    chk("auto_rd0_addr", 32'(address), 32'd0);
    @(negedge clock);
    chk("auto_rd1_read", 32'(read), 32'd1);
    chk("auto_rd1_addr", 32'(address), 32'd1);
    wait_drain("auto", 20);

    // Wrong ID word.
    @(negedge clock);
    sl_id = ID_BAD;
    push(1'b0, 1'b1, 1'b0, ID_BAD, TS_OK, 8'd1, cyc + 3);
    pulse_start();
    wait_drain("bad_id", 20);

    // Three stall cycles on each read.
    @(negedge clock);
    sl_id = ID_OK;
    sl_stall_id = 3;
    sl_stall_ts = 3;
    push(1'b1, 1'b0, 1'b0, ID_OK, TS_OK, 8'd1, cyc + 9);
    pulse_start();
    wait_drain("stall3", 30);

    // Timestamp read stuck in waitrequest: times out after 4 stalled cycles.
    @(negedge clock);
    sl_stall_id = 0;
    sl_stall_ts = 1000;
    sl_ts = TS_ALT;
    push(1'b0, 1'b1, 1'b1, ID_OK, TS_OK, 8'd2, cyc + 6);
    pulse_start();
    wait_drain("timeout", 30);
    sl_stall_ts = 0;
    sl_ts = TS_OK;
    repeat (3) @(negedge clock);
    chk("hold_timeout", 32'(timeout), 32'd1);
    chk("hold_fail",    32'(fail),    32'd1);
    chk("hold_pass",    32'(pass),    32'd0);
    chk("hold_ts",      ts_value,     TS_OK);

    // Start during RD_TS is ignored; start in the DONE cycle begins a new check.
    c0 = cyc;
    sl_id = ID_BAD;
    start = 1'b1;
    push(1'b0, 1'b1, 1'b0, ID_BAD, TS_OK, 8'd3, c0 + 3);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    sl_id = ID_OK;
    push(1'b1, 1'b0, 1'b0, ID_OK, TS_OK, 8'd3, c0 + 6);
    @(negedge clock);
    start = 1'b0;
    chk("restart_pass_clr", 32'(pass),    32'd0);
    chk("restart_fail_clr", 32'(fail),    32'd0);
    chk("restart_to_clr",   32'(timeout), 32'd0);
    chk("restart_busy",     32'(busy),    32'd1);
    wait_drain("restart", 20);

    // Reset while the ID read is stalled: read drops, no done pulse.
    @(negedge clock);
    sl_stall_id = 1000;
    pulse_start();
    @(negedge clock);
    chk("pre_reset_read", 32'(read), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset("midreset");
    @(negedge clock);
    sl_stall_id = 0;
    reset_n = 1'b1;
    push(1'b1, 1'b0, 1'b0, ID_OK, TS_OK, 8'd0, cyc + 3);
    wait_drain("post_reset", 20);

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
